// File: rtl/arb_pkg.sv
// Shared types and constants for the arbiter family.
package arb_pkg;

  // Offer FSM: IDLE has nothing on the output; OFFER holds a stable winner.
  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_e;

  // Values of the mode input.
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/prio_pick.sv
// Combinational winner picker.
// Fixed mode returns the highest set index of i_vec.
// Round-robin mode returns the first set index at or above i_start, wrapping
// past N-1 to 0. It does this in three steps: rotate i_vec so that i_start
// lands on bit 0, take the lowest set bit, then rotate that index back.
// i_start must be below N.
module prio_pick
  import arb_pkg::*;
#(
  parameter  int N     = 8,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_vec,
  input  logic [IDX_W-1:0] i_start,
  input  logic             i_mode,
  output logic [IDX_W-1:0] o_idx,
  output logic [N-1:0]     o_onehot,
  output logic             o_any
);

  logic [N-1:0]     w_rot;
  logic [IDX_W-1:0] w_hi_idx;
  logic [IDX_W-1:0] w_lo_idx;

  // Returns (a + b) mod N. Both operands are already below N.
  function automatic logic [IDX_W-1:0] wrap_add(input int a, input int b);
    int s;
    s = a + b;
    if (s >= N) s = s - N;
    return IDX_W'(s);
  endfunction

  // Rotate the request vector so that the start pointer becomes bit 0.
  always_comb begin
    w_rot = '0;
    for (int i = 0; i < N; i++) begin
      w_rot[i] = i_vec[wrap_add(i, int'(i_start))];
    end
  end

  // Find the MSB of the raw vector (fixed priority). The last match wins.
  always_comb begin
    w_hi_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (i_vec[i]) w_hi_idx = IDX_W'(i);
    end
  end

  // Find the LSB of the rotated vector. The last match in a downward scan wins.
  always_comb begin
    w_lo_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) w_lo_idx = IDX_W'(i);
    end
  end

  // Choose by mode, undo the rotation, and form the one-hot output.
  always_comb begin
    o_any = |i_vec;
    if (i_mode == MODE_FIXED) begin
      o_idx = w_hi_idx;
    end else begin
      o_idx = wrap_add(int'(w_lo_idx), int'(i_start));
    end
    o_onehot = o_any ? (N'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/priority_arbiter_rr.sv
// Registered N-way request arbiter.
// Request bits are sticky: they collect in a pending vector. The arbiter picks
// one winner at a time, by fixed priority or round robin, and offers it
// downstream over a valid/ready handshake.
//
// Handshake: once out_valid rises, out_idx and out_onehot stay constant until
// a cycle in which out_valid and out_ready are both high. That cycle is the
// transfer. out_valid is never withdrawn without a transfer. On the transfer
// edge the next winner, if any, is loaded, so a fully ready consumer gets one
// grant per cycle.
module priority_arbiter_rr
  import arb_pkg::*;
#(
  parameter  int N     = 8,
  parameter  int CNT_W = 8,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             rr_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [N-1:0]     out_onehot,
  output logic [N-1:0]     pending,
  output logic [CNT_W-1:0] drop_cnt,
  output arb_state_e       dbg_state
);

  arb_state_e       r_state;
  logic [N-1:0]     r_pend;
  logic [IDX_W-1:0] r_idx;
  logic [N-1:0]     r_onehot;
  logic [IDX_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_drop;

  arb_state_e       w_state_nx;
  logic             w_hs;
  logic [N-1:0]     w_clr;
  logic [N-1:0]     w_pend_nx;
  logic             w_drop;
  logic [IDX_W-1:0] w_ptr_adv;
  logic [IDX_W-1:0] w_start;
  logic [IDX_W-1:0] w_pick_idx;
  logic [N-1:0]     w_pick_oh;
  logic             w_pick_any;
  logic             w_load;
  logic             w_release;

  // Compute the handshake and the next pending vector. A new request beats
  // the clear of its own bit. A request that lands on a bit already pending,
  // and not being cleared, is a drop.
  always_comb begin
    w_hs      = (r_state == OFFER) && out_ready;
    w_clr     = w_hs ? r_onehot : '0;
    w_pend_nx = (r_pend & ~w_clr) | req;
    w_drop    = |(req & r_pend & ~w_clr);
    w_ptr_adv = (r_idx == IDX_W'(N - 1)) ? '0 : r_idx + 1'b1;
    // A round-robin search made on a transfer starts after the granted index.
    w_start   = w_hs ? w_ptr_adv : r_ptr;
  end

  prio_pick #(
    .N (N)
  ) u_pick (
    .i_vec    (w_pend_nx),
    .i_start  (w_start),
    .i_mode   (rr_mode),
    .o_idx    (w_pick_idx),
    .o_onehot (w_pick_oh),
    .o_any    (w_pick_any)
  );

  // Next-state logic: decide whether to load a new winner or drop valid.
  always_comb begin
    w_state_nx = r_state;
    w_load     = 1'b0;
    w_release  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_any) begin
          w_load     = 1'b1;
          w_state_nx = OFFER;
        end
      end
      OFFER: begin
        if (w_hs) begin
          if (w_pick_any) begin
            w_load = 1'b1;
          end else begin
            w_release  = 1'b1;
            w_state_nx = IDLE;
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  // Hold the offered winner. rr_mode matters only at load time. The index
  // keeps its last value when valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx    <= '0;
      r_onehot <= '0;
    end else if (w_load) begin
      r_idx    <= w_pick_idx;
      r_onehot <= w_pick_oh;
    end else if (w_release) begin
      r_onehot <= '0;
    end
  end

  // Sticky pending vector. The offered bit stays set until it is transferred.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pend <= '0;
    else        r_pend <= w_pend_nx;
  end

  // The round-robin pointer moves past each granted index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_ptr <= '0;
    else if (w_hs) r_ptr <= w_ptr_adv;
  end

  // Saturating drop counter: at most one count per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_drop <= '0;
    else if (w_drop && r_drop != '1)  r_drop <= r_drop + 1'b1;
  end

  assign out_valid  = (r_state == OFFER);
  assign out_idx    = r_idx;
  assign out_onehot = r_onehot;
  assign pending    = r_pend;
  assign drop_cnt   = r_drop;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_priority_arbiter_rr.sv
// Testbench for priority_arbiter_rr.
// Directed scenarios come first, then a random run checked against a cycle
// model of the arbiter's rules. A second instance with a 2-bit drop counter
// receives the same inputs.
module tb_priority_arbiter_rr;
  import arb_pkg::*;

  localparam int N     = 8;
  localparam int IDX_W = 3;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req = '0;
  logic             rr_mode = 1'b0;
  logic             out_ready = 1'b0;

  logic             out_valid;
  logic [IDX_W-1:0] out_idx;
  logic [N-1:0]     out_onehot;
  logic [N-1:0]     pending;
  logic [CNT_W-1:0] drop_cnt;
  arb_state_e       dbg_state;

  logic             out_valid2;
  logic [IDX_W-1:0] out_idx2;
  logic [N-1:0]     out_onehot2;
  logic [N-1:0]     pending2;
  logic [1:0]       drop_cnt2;
  arb_state_e       dbg_state2;

  int checks = 0;
  int errors = 0;
  logic [IDX_W-1:0] exp_q[$];

  // Model state.
  logic [N-1:0] m_pend;
  bit           m_valid;
  int           m_idx;
  int           m_ptr;
  int           m_drop;
  int           m_drop2;

  priority_arbiter_rr #(.N(N), .CNT_W(CNT_W)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .rr_mode    (rr_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_idx    (out_idx),
    .out_onehot (out_onehot),
    .pending    (pending),
    .drop_cnt   (drop_cnt),
    .dbg_state  (dbg_state)
  );

  priority_arbiter_rr #(.N(N), .CNT_W(2)) u_dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .rr_mode    (rr_mode),
    .out_valid  (out_valid2),
    .out_ready  (out_ready),
    .out_idx    (out_idx2),
    .out_onehot (out_onehot2),
    .pending    (pending2),
    .drop_cnt   (drop_cnt2),
    .dbg_state  (dbg_state2)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Winner rule: fixed mode takes the highest index; round robin takes the
  // first set index counting up from ptr, modulo N.
  function automatic int model_pick(logic [N-1:0] v, int ptr, logic mode);
    if (mode == MODE_FIXED) begin
      for (int i = N - 1; i >= 0; i--) if (v[i]) return i;
    end else begin
      for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return 0;
  endfunction

  function automatic void model_reset();
    m_pend  = '0;
    m_valid = 0;
    m_idx   = 0;
    m_ptr   = 0;
    m_drop  = 0;
    m_drop2 = 0;
  endfunction

  // Advance the model by one clock, using the inputs currently driven.
  function automatic void model_step();
    logic [N-1:0] nxt;
    bit granted;
    bit collide;
    int ptr;
    if (!rst_n) begin
      model_reset();
      return;
    end
    granted = m_valid && out_ready;
    ptr     = m_ptr;
    nxt     = m_pend;
    collide = 0;
    for (int i = 0; i < N; i++)
      if (req[i] && m_pend[i] && !(granted && i == m_idx)) collide = 1;
    if (granted) begin
      nxt[m_idx] = 1'b0;
      ptr = (m_idx + 1) % N;
    end
    nxt = nxt | req;
    if (collide) begin
      if (m_drop < 255) m_drop++;
      if (m_drop2 < 3)  m_drop2++;
    end
    if (!m_valid || granted) begin
      if (nxt != '0) begin
        m_valid = 1;
        m_idx   = model_pick(nxt, ptr, rr_mode);
      end else begin
        m_valid = 0;
      end
    end
    m_ptr  = ptr;
    m_pend = nxt;
  endfunction

  // Advance one clock. Samples are taken 1 time unit after the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = '0;
    out_ready = 1'b0;
    rr_mode   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 8'hFF;
    out_ready = 1'b1;
    repeat (3) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    checks++; if (out_idx !== 3'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", out_idx); end
    checks++; if (out_onehot !== 8'h00) begin errors++; $display("FAIL reset_onehot got=%h exp=00", out_onehot); end
    checks++; if (pending !== 8'h00) begin errors++; $display("FAIL reset_pending got=%h exp=00", pending); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=IDLE", dbg_state); end
    rst_n = 1'b1;
    req   = 8'h00;
    tick();
    checks++; if (pending !== 8'h00) begin errors++; $display("FAIL reset_first_pending got=%h exp=00", pending); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_first_valid got=%0b exp=0", out_valid); end
  endtask

  task automatic test_fixed();
    logic [IDX_W-1:0] e;
    do_reset();
    rr_mode   = MODE_FIXED;
    out_ready = 1'b1;
    exp_q = '{3'd5, 3'd2, 3'd1};
    req = 8'b0010_0110;
    tick();
    req = '0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++; if (out_valid !== 1'b1 || out_idx !== e) begin errors++; $display("FAIL fixed_grant got v=%0b idx=%0d exp v=1 idx=%0d", out_valid, out_idx, e); end
      checks++; if (out_onehot !== (N'(1) << e)) begin errors++; $display("FAIL fixed_onehot got=%h exp=%h", out_onehot, N'(1) << e); end
      tick();
    end
    checks++; if (out_valid !== 1'b0 || out_onehot !== 8'h00) begin errors++; $display("FAIL fixed_end got v=%0b oh=%h exp v=0 oh=00", out_valid, out_onehot); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL fixed_drop got=%0d exp=0", drop_cnt); end
  endtask

  task automatic test_round_robin();
    logic [IDX_W-1:0] e;
    do_reset();
    rr_mode   = MODE_RR;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) exp_q.push_back(IDX_W'(i));
    req = 8'hFF;
    tick();
    req = '0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++; if (out_valid !== 1'b1 || out_idx !== e) begin errors++; $display("FAIL rr_sweep got v=%0b idx=%0d exp v=1 idx=%0d", out_valid, out_idx, e); end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_sweep_end got=%0b exp=0", out_valid); end
    exp_q = '{3'd0, 3'd7};
    req = 8'b1000_0001;
    tick();
    req = '0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++; if (out_valid !== 1'b1 || out_idx !== e) begin errors++; $display("FAIL rr_wrap got v=%0b idx=%0d exp v=1 idx=%0d", out_valid, out_idx, e); end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_wrap_end got=%0b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    rr_mode   = MODE_FIXED;
    out_ready = 1'b0;
    req = 8'b0000_1000;
    tick();
    req = '0;
    for (int c = 0; c < 5; c++) begin
      req = (c == 2) ? 8'b0100_0000 : 8'h00;
      tick();
      checks++; if (out_valid !== 1'b1 || out_idx !== 3'd3) begin errors++; $display("FAIL bp_hold got v=%0b idx=%0d exp v=1 idx=3", out_valid, out_idx); end
    end
    req = '0;
    checks++; if (pending !== 8'h48) begin errors++; $display("FAIL bp_pending got=%h exp=48", pending); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || out_idx !== 3'd6) begin errors++; $display("FAIL bp_next got v=%0b idx=%0d exp v=1 idx=6", out_valid, out_idx); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_end got=%0b exp=0", out_valid); end
  endtask

  task automatic test_collision();
    do_reset();
    rr_mode   = MODE_FIXED;
    out_ready = 1'b0;
    req = 8'h10;
    tick();
    req = '0;
    for (int k = 0; k < 3; k++) begin
      req = 8'h10; tick();
      req = 8'h00; tick();
    end
    checks++; if (drop_cnt !== 8'd3) begin errors++; $display("FAIL coll_drop3 got=%0d exp=3", drop_cnt); end
    checks++; if (drop_cnt2 !== 2'd3) begin errors++; $display("FAIL coll_drop3_w2 got=%0d exp=3", drop_cnt2); end
    checks++; if (pending !== 8'h10 || out_idx !== 3'd4) begin errors++; $display("FAIL coll_pending got p=%h idx=%0d exp p=10 idx=4", pending, out_idx); end
    for (int k = 0; k < 2; k++) begin
      req = 8'h10; tick();
      req = 8'h00; tick();
    end
    checks++; if (drop_cnt !== 8'd5) begin errors++; $display("FAIL coll_drop5 got=%0d exp=5", drop_cnt); end
    checks++; if (drop_cnt2 !== 2'd3) begin errors++; $display("FAIL coll_sat_w2 got=%0d exp=3", drop_cnt2); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || pending !== 8'h00) begin errors++; $display("FAIL coll_single_grant got v=%0b p=%h exp v=0 p=00", out_valid, pending); end
  endtask

  task automatic test_req_beats_clear();
    do_reset();
    rr_mode   = MODE_FIXED;
    out_ready = 1'b0;
    req = 8'h04;
    tick();
    out_ready = 1'b1;
    tick();
    req = 8'h00;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_idx !== 3'd2) begin errors++; $display("FAIL rbc_reoffer got v=%0b idx=%0d exp v=1 idx=2", out_valid, out_idx); end
    checks++; if (pending !== 8'h04 || drop_cnt !== 8'd0) begin errors++; $display("FAIL rbc_pending got p=%h d=%0d exp p=04 d=0", pending, drop_cnt); end
    tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_valid got=%0b exp=0", out_valid); end
    checks++; if (pending !== 8'h00 || out_onehot !== 8'h00) begin errors++; $display("FAIL async_pending got p=%h oh=%h exp 00", pending, out_onehot); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [N-1:0] exp_oh;
    int r;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      r = $urandom_range(0, 9);
      if (r < 5)      req = '0;
      else if (r < 8) req = N'(1) << $urandom_range(0, N - 1);
      else            req = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) rr_mode = ~rr_mode;
      tick();
      exp_oh = m_valid ? (N'(1) << m_idx) : '0;
      checks++; if (out_valid !== m_valid) begin errors++; $display("FAIL rnd_valid c=%0d got=%0b exp=%0b", c, out_valid, m_valid); end
      checks++; if (out_idx !== IDX_W'(m_idx)) begin errors++; $display("FAIL rnd_idx c=%0d got=%0d exp=%0d", c, out_idx, m_idx); end
      checks++; if (out_onehot !== exp_oh) begin errors++; $display("FAIL rnd_onehot c=%0d got=%h exp=%h", c, out_onehot, exp_oh); end
      checks++; if (pending !== m_pend) begin errors++; $display("FAIL rnd_pending c=%0d got=%h exp=%h", c, pending, m_pend); end
      checks++; if (drop_cnt !== CNT_W'(m_drop) || drop_cnt2 !== 2'(m_drop2)) begin errors++; $display("FAIL rnd_drop c=%0d got=%0d/%0d exp=%0d/%0d", c, drop_cnt, drop_cnt2, m_drop, m_drop2); end
      checks++; if (dbg_state !== (m_valid ? OFFER : IDLE)) begin errors++; $display("FAIL rnd_state c=%0d got=%0d exp_valid=%0b", c, dbg_state, m_valid); end
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_round_robin();
    test_backpressure();
    test_collision();
    test_req_beats_clear();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
